// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - issue/result bundle between the execute stage and the HI/LO multiply/divide unit
interface mdu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential MIPS multiply/divide unit with HI/LO registers
// Magnitude datapath: shift-add multiply and restoring divide, sign fixed up in a final cycle.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mdu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  logic               is_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH:0]     rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_iter;

  always_comb begin
    in_signed = ~bus.op[0];
    in_neg_a  = in_signed & bus.A[WIDTH-1];
    in_neg_b  = in_signed & bus.B[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    in_mag_a  = in_neg_a ? (~bus.A + 1'b1) : bus.A;
    in_mag_b  = in_neg_b ? (~bus.B + 1'b1) : bus.B;
  end

  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, mag_b});
    rem_next  = rem_ge ? (rem_shift - {1'b0, mag_b}) : rem_shift;
    prod_fix  = neg_res ? (~prod + 1'b1) : prod;
    quo_fix   = neg_res ? (~quo + 1'b1) : quo;
    rem_fix   = neg_rem ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start) next_state = S_CALC;
      S_CALC:  if (last_iter) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div  <= bus.op[1];
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            a_raw   <= bus.A;
            neg_res <= in_neg_a ^ in_neg_b;
            neg_rem <= in_neg_a;
            b_zero  <= (bus.B == '0);
            prod    <= {{WIDTH{1'b0}}, in_mag_b};
            rem     <= '0;
            quo     <= in_mag_a;
            cnt     <= '0;
          end else begin
            // Register moves share one data bus; asserting both writes the same value to each
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], rem_ge};
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (!is_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi_q <= a_raw;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
